// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM state codes
// and helpers for request legality and counter sizing.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t IDLE  = 2'd0;
  localparam lsu_state_t ISSUE = 2'd1;
  localparam lsu_state_t WAIT  = 2'd2;
  localparam lsu_state_t RESP  = 2'd3;

  // Width of the WAIT-state timeout counter; kept at least 1 bit when disabled.
  function automatic int unsigned cnt_width(input int unsigned timeout_cyc);
    int unsigned w;
    w = $clog2(timeout_cyc + 1);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
    logic ok;
    if (we) begin
      ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    end else begin
      ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store strobes/replication and load
// extraction with sign/zero extension. Shared with the cache fill path.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  a,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  wstb,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;

  always_comb begin
    wstb      = 4'b1111;
    wdata_out = wdata_in;
    unique case (funct3[1:0])
      2'b00: begin
        wstb      = 4'b0001 << a;
        wdata_out = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        wstb      = 4'b0011 << {a[1], 1'b0};
        wdata_out = {2{wdata_in[15:0]}};
      end
      default: begin
        wstb      = 4'b1111;
        wdata_out = wdata_in;
      end
    endcase
  end

  // Halfwords only honour a[1]; a misaligned a[0] is silently dropped.
  assign byte_shift = rdata_in >> {a, 3'b000};
  assign half_shift = rdata_in >> {a[1], 4'b0000};

  always_comb begin
    rdata_out = rdata_in;
    case (funct3)
      F3_B:    rdata_out = {{24{byte_shift[7]}}, byte_shift[7:0]};
      F3_BU:   rdata_out = {24'h0, byte_shift[7:0]};
      F3_H:    rdata_out = {{16{half_shift[15]}}, half_shift[15:0]};
      F3_HU:   rdata_out = {16'h0, half_shift[15:0]};
      default: rdata_out = rdata_in;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// One-outstanding load/store unit between the memory stage and the data port.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [2:0]  REQ_FUNCT3,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        D_MEM_VALID,
  output logic [3:0]  D_MEM_WSTB,
  output logic [31:0] D_MEM_ADDR,
  output logic [31:0] D_MEM_WDATA,
  input  logic        D_MEM_READY,
  input  logic [31:0] D_MEM_RDATA
);

  localparam int unsigned CntW = cnt_width(TIMEOUT_CYC);
  localparam bit TimeoutEn = (TIMEOUT_CYC != 0);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  lsu_state_t state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      a_q, a_d;
  logic            we_q, we_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mem_valid_q, mem_valid_d;
  logic [3:0]      mem_wstb_q, mem_wstb_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic        misaligned;
  logic        access_ok;
  logic [2:0]  la_funct3;
  logic [1:0]  la_a;
  logic [3:0]  la_wstb;
  logic [31:0] la_wdata;
  logic [31:0] la_rdata;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((REQ_FUNCT3[1:0] == 2'b01) && REQ_ADDR[0]) ||
                      ((REQ_FUNCT3[1:0] == 2'b10) && (REQ_ADDR[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign access_ok = f3_legal(REQ_WE, REQ_FUNCT3) && !misaligned;

  // Store side steers live request fields; load side uses the latched ones.
  assign la_funct3 = (state_q == IDLE) ? REQ_FUNCT3    : f3_q;
  assign la_a      = (state_q == IDLE) ? REQ_ADDR[1:0] : a_q;

  lsu_lane_align u_lane_align (
    .funct3    (la_funct3),
    .a         (la_a),
    .wdata_in  (REQ_WDATA),
    .rdata_in  (D_MEM_RDATA),
    .wstb      (la_wstb),
    .wdata_out (la_wdata),
    .rdata_out (la_rdata)
  );

  always_comb begin
    state_d     = state_q;
    f3_d        = f3_q;
    a_d         = a_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    mem_valid_d = 1'b0;
    mem_wstb_d  = mem_wstb_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (REQ_VALID) begin
          f3_d  = REQ_FUNCT3;
          a_d   = REQ_ADDR[1:0];
          we_d  = REQ_WE;
          cnt_d = '0;
          if (access_ok) begin
            mem_valid_d = 1'b1;
            mem_wstb_d  = REQ_WE ? la_wstb : 4'b0000;
            mem_addr_d  = {REQ_ADDR[31:2], 2'b00};
            mem_wdata_d = REQ_WE ? la_wdata : 32'h0;
            state_d     = ISSUE;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 32'h0;
            rsp_err_d   = 1'b1;
            state_d     = RESP;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (D_MEM_READY) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? 32'h0 : la_rdata;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else if (TimeoutEn && (cnt_q == CntLast)) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        // RESP: pulse ends, strobes clear so a stray READY cannot look like a write.
        mem_wstb_d  = 4'b0000;
        rsp_rdata_d = 32'h0;
        rsp_err_d   = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      f3_q        <= 3'b000;
      a_q         <= 2'b00;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_wstb_q  <= 4'b0000;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      f3_q        <= f3_d;
      a_q         <= a_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      mem_valid_q <= mem_valid_d;
      mem_wstb_q  <= mem_wstb_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign REQ_READY   = (state_q == IDLE);
  assign D_MEM_VALID = mem_valid_q;
  assign D_MEM_WSTB  = mem_wstb_q;
  assign D_MEM_ADDR  = mem_addr_q;
  assign D_MEM_WDATA = mem_wdata_q;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_RDATA   = rsp_rdata_q;
  assign RSP_ERR     = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a single-cycle word memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VALID, REQ_READY, REQ_WE;
  logic [2:0]  REQ_FUNCT3;
  logic [31:0] REQ_ADDR, REQ_WDATA;
  logic        RSP_VALID, RSP_ERR;
  logic [31:0] RSP_RDATA;
  logic        D_MEM_VALID, D_MEM_READY;
  logic [3:0]  D_MEM_WSTB;
  logic [31:0] D_MEM_ADDR, D_MEM_WDATA, D_MEM_RDATA;

  load_store_unit #(.TIMEOUT_CYC(4)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .REQ_VALID   (REQ_VALID),
    .REQ_READY   (REQ_READY),
    .REQ_WE      (REQ_WE),
    .REQ_FUNCT3  (REQ_FUNCT3),
    .REQ_ADDR    (REQ_ADDR),
    .REQ_WDATA   (REQ_WDATA),
    .RSP_VALID   (RSP_VALID),
    .RSP_RDATA   (RSP_RDATA),
    .RSP_ERR     (RSP_ERR),
    .D_MEM_VALID (D_MEM_VALID),
    .D_MEM_WSTB  (D_MEM_WSTB),
    .D_MEM_ADDR  (D_MEM_ADDR),
    .D_MEM_WDATA (D_MEM_WDATA),
    .D_MEM_READY (D_MEM_READY),
    .D_MEM_RDATA (D_MEM_RDATA)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Memory model: READY the cycle after VALID, byte-strobed writes.
  logic [31:0] mem [256];
  logic        mem_en, mem_clr, mem_rdy, late_rdy;
  logic [31:0] mem_rd;
  assign D_MEM_READY = mem_rdy | late_rdy;
  assign D_MEM_RDATA = mem_rd;

  always @(posedge CLK) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[128] <= 32'h0000_00AA;
      mem_rdy  <= 1'b0;
      mem_rd   <= 32'h0;
    end else begin
      mem_rdy <= 1'b0;
      if (D_MEM_VALID && mem_en) begin
        mem_rdy <= 1'b1;
        mem_rd  <= mem[D_MEM_ADDR[9:2]];
        for (int b = 0; b < 4; b++)
          if (D_MEM_WSTB[b]) mem[D_MEM_ADDR[9:2]][8*b +: 8] <= D_MEM_WDATA[8*b +: 8];
      end
    end
  end

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          base;
  } rsp_t;

  typedef struct {
    string       name;
    logic [3:0]  wstb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_wdata;
  } mreq_t;

  rsp_t  rsp_q[$];
  mreq_t mreq_q[$];
  int checks = 0;
  int errors = 0;
  int rsp_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  // Response monitor: {latency, err, rdata} against the queued expectation.
  initial forever begin
    rsp_t e;
    @(negedge CLK);
    if (!RST && RSP_VALID) begin
      rsp_count++;
      if (rsp_q.size() == 0) begin
        chk("rsp_unexpected", {32'h0, RSP_RDATA}, 64'h0 | {31'h0, ~RSP_VALID, 32'h0});
      end else begin
        e = rsp_q.pop_front();
        chk({"rsp_", e.name},
            {16'(cyc - e.base), 15'h0, RSP_ERR, RSP_RDATA},
            {16'(e.lat), 15'h0, e.err, e.rdata});
      end
    end
  end

  // Memory-port monitor: {wstb, addr, wdata} per D_MEM_VALID pulse.
  initial forever begin
    mreq_t m;
    @(negedge CLK);
    if (!RST && D_MEM_VALID) begin
      if (mreq_q.size() == 0) begin
        chk("mem_unexpected", {63'h0, D_MEM_VALID}, 64'h0);
      end else begin
        m = mreq_q.pop_front();
        chk({"mem_", m.name},
            {28'h0, D_MEM_WSTB, D_MEM_ADDR} ^ {32'h0, (m.chk_wdata ? D_MEM_WDATA : 32'h0)} ,
            {28'h0, m.wstb, m.addr} ^ {32'h0, (m.chk_wdata ? m.wdata : 32'h0)});
      end
    end
  end

  task automatic issue(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                       input logic has_mem, input logic [3:0] exp_wstb,
                       input logic [31:0] exp_mdata);
    rsp_t  r;
    mreq_t m;
    int    n = 0;
    @(negedge CLK);
    while (!REQ_READY && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!REQ_READY) chk({"ready_", name}, {63'h0, REQ_READY}, 64'h1);
    REQ_VALID  = 1'b1;
    REQ_WE     = we;
    REQ_FUNCT3 = f3;
    REQ_ADDR   = addr;
    REQ_WDATA  = wdata;
    r = '{name: name, rdata: exp_rdata, err: exp_err, lat: lat, base: cyc};
    rsp_q.push_back(r);
    if (has_mem) begin
      m = '{name: name, wstb: exp_wstb, addr: {addr[31:2], 2'b00}, wdata: exp_mdata,
            chk_wdata: we};
      mreq_q.push_back(m);
    end
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((rsp_q.size() != 0 || mreq_q.size() != 0) && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (rsp_q.size() != 0 || mreq_q.size() != 0) begin
      chk({"drain_", name}, 64'(rsp_q.size() + mreq_q.size()), 64'h0);
      rsp_q.delete();
      mreq_q.delete();
    end
  endtask

  task automatic req(input string name, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                     input logic has_mem, input logic [3:0] exp_wstb,
                     input logic [31:0] exp_mdata);
    issue(name, we, f3, addr, wdata, exp_rdata, exp_err, lat, has_mem, exp_wstb, exp_mdata);
    drain(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int saved;
    RST        = 1'b1;
    mem_clr    = 1'b1;
    mem_en     = 1'b1;
    late_rdy   = 1'b0;
    REQ_VALID  = 1'b0;
    REQ_WE     = 1'b0;
    REQ_FUNCT3 = 3'b000;
    REQ_ADDR   = 32'h0;
    REQ_WDATA  = 32'h0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_state",
        {REQ_READY, D_MEM_VALID, D_MEM_WSTB, RSP_VALID, RSP_ERR, D_MEM_ADDR | D_MEM_WDATA
         | RSP_RDATA},
        {1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0});
    RST     = 1'b0;
    mem_clr = 1'b0;

    req("sw_100",   1, F3_W,  32'h100, 32'hDEADBEEF, 32'h0,        0, 3, 1, 4'b1111, 32'hDEADBEEF);
    req("lb_101",   0, F3_B,  32'h101, 32'h0,        32'hFFFFFFBE, 0, 3, 1, 4'b0000, 32'h0);
    req("lbu_103",  0, F3_BU, 32'h103, 32'h0,        32'h000000DE, 0, 3, 1, 4'b0000, 32'h0);
    req("lh_102",   0, F3_H,  32'h102, 32'h0,        32'hFFFFDEAD, 0, 3, 1, 4'b0000, 32'h0);
    req("sh_202",   1, F3_H,  32'h202, 32'h00001234, 32'h0,        0, 3, 1, 4'b1100, 32'h12341234);
    req("sb_201",   1, F3_B,  32'h201, 32'h00000080, 32'h0,        0, 3, 1, 4'b0010, 32'h80808080);
    req("lw_200",   0, F3_W,  32'h200, 32'h0,        32'h123480AA, 0, 3, 1, 4'b0000, 32'h0);
    req("lh_200",   0, F3_H,  32'h200, 32'h0,        32'hFFFF80AA, 0, 3, 1, 4'b0000, 32'h0);
    req("lhu_202",  0, F3_HU, 32'h202, 32'h0,        32'h00001234, 0, 3, 1, 4'b0000, 32'h0);
    req("ill_ld011", 0, 3'b011, 32'h100, 32'h0,      32'h0,        1, 1, 0, 4'b0000, 32'h0);
    req("ill_st100", 1, 3'b100, 32'h100, 32'h5555,   32'h0,        1, 1, 0, 4'b0000, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    req("mis_lw_102", 0, F3_W, 32'h102, 32'h0,       32'h0,        1, 1, 0, 4'b0000, 32'h0);
`else
    req("mis_lw_102", 0, F3_W, 32'h102, 32'h0,       32'hDEADBEEF, 0, 3, 1, 4'b0000, 32'h0);
`endif

    // Memory never answers: four WAIT cycles then an error response.
    mem_en = 1'b0;
    req("timeout",  0, F3_W,  32'h100, 32'h0,        32'h0,        1, 6, 1, 4'b0000, 32'h0);
    @(negedge CLK);
    saved    = rsp_count;
    late_rdy = 1'b1;
    @(negedge CLK);
    late_rdy = 1'b0;
    repeat (4) @(negedge CLK);
    chk("late_ready_dropped", 64'(rsp_count), 64'(saved));

    // Reset while WAITing on a silent memory.
    issue("rst_mid", 0, F3_W, 32'h100, 32'h0, 32'h0, 0, 3, 1, 4'b0000, 32'h0);
    repeat (2) @(posedge CLK);
    #2;
    saved = rsp_count;
    RST   = 1'b1;
    #1;
    chk("rst_async_outputs",
        {REQ_READY, D_MEM_VALID, D_MEM_WSTB, RSP_VALID, RSP_ERR, D_MEM_ADDR | D_MEM_WDATA
         | RSP_RDATA},
        {1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0});
    rsp_q.delete();
    mreq_q.delete();
    @(negedge CLK);
    RST    = 1'b0;
    mem_en = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_no_response", 64'(rsp_count), 64'(saved));
    req("post_rst_lw", 0, F3_W, 32'h100, 32'h0,     32'hDEADBEEF, 0, 3, 1, 4'b0000, 32'h0);

    repeat (3) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
